// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers: handshake state encoding,
// per-stage payload structs and their packed widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] rs2;
    logic        cmp;
    logic [31:0] jmp_pc;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } mem_wb_t;

  localparam int unsigned IF_ID_W  = $bits(if_id_t);
  localparam int unsigned ID_EX_W  = $bits(id_ex_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

  // Number of live entries held for a given state; unknown encodings read as empty.
  function automatic logic [1:0] occ_of(input pipe_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      PS_BUSY: occ = 2'd1;
      PS_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register with async reset, load enable and a synchronous
// clear back to RESET_VAL (clear wins over load).
module pipe_data_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = RESET_VAL;
    end else if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer: main register drives
// out_data, skid catches the beat accepted while downstream stalls.
//
// state    | meaning
// PS_EMPTY | nothing held, out_valid=0, in_ready=1
// PS_BUSY  | main holds the head payload, skid free
// PS_FULL  | main holds head, skid holds next; upstream stalled
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_e      state_q;
  pipe_state_e      state_d;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             main_from_skid;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Handshake outputs come from the state register only, so out_ready never
  // reaches in_ready combinationally. Illegal encodings advertise neither.
  assign in_ready  = (state_q == PS_EMPTY) || (state_q == PS_BUSY);
  assign out_valid = (state_q == PS_BUSY)  || (state_q == PS_FULL);
  assign occupancy = occ_of(state_q);
  assign out_data  = main_q;

  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PS_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;

    case (state_q)
      PS_EMPTY: begin
        if (in_fire) begin
          state_d = PS_BUSY;
          main_en = 1'b1;
        end
      end
      PS_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          state_d = PS_FULL;
          skid_en = 1'b1;
        end else if (out_fire) begin
          state_d = PS_EMPTY;
        end
      end
      PS_FULL: begin
        if (out_fire) begin
          state_d        = PS_BUSY;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_d = PS_EMPTY;
      end
    endcase

    // Flush discards anything accepted this cycle; registers are cleared below.
    if (flush) begin
      state_d        = PS_EMPTY;
      main_en        = 1'b0;
      main_from_skid = 1'b0;
      skid_en        = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .clr   (flush),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .clr   (flush),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule
